// File: rtl/mcb_sram_resp_pkg.sv
// Shared types and helpers for the MCB SRAM responder: state encoding,
// burst-length decoding and RAM address composition.
package mcb_sram_resp_pkg;

  localparam int PKG_B_W = 2;
  localparam int PKG_R_W = 13;
  localparam int PKG_C_W = 9;
  localparam int BEAT_W  = 4;

  localparam logic [1:0] BL_ILLEGAL = 2'd3;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WR,
    ST_WR_DRAIN,
    ST_RD,
    ST_RD_DRAIN
  } state_e;

  // Beats per burst: (bl + 1) * 4; the illegal code is filtered before use.
  function automatic logic [BEAT_W-1:0] beat_count(input logic [1:0] bl);
    return {bl + 2'd1, 2'b00};
  endfunction

  function automatic logic [PKG_B_W+PKG_R_W+PKG_C_W-1:0] mem_addr(
    input logic [PKG_B_W-1:0] ba,
    input logic [PKG_R_W-1:0] ra,
    input logic [PKG_C_W-1:0] col
  );
    return {ba, ra, col};
  endfunction

endpackage

// File: rtl/mcb_resp_ram.sv
// Single-clock simple dual-port RAM: byte-enabled write port, one-cycle
// registered read port that holds its value when no read is issued.
module mcb_resp_ram #(
  parameter int A_W  = 10,
  parameter int D_W  = 32,
  parameter int BE_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [A_W-1:0]  waddr,
  input  logic [D_W-1:0]  wdata,
  input  logic [BE_W-1:0] wbe,
  input  logic            re,
  input  logic [A_W-1:0]  raddr,
  output logic [D_W-1:0]  rdata
);

  logic [D_W-1:0] mem [0:(1<<A_W)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (wbe[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/mcb_sram_resp.sv
// MCB back-end responder backed by on-chip RAM: accepts burst commands,
// requests write beats with a fixed data latency, returns read beats.
module mcb_sram_resp
  import mcb_sram_resp_pkg::*;
#(
  parameter int MCB_B_W  = PKG_B_W,
  parameter int MCB_R_W  = PKG_R_W,
  parameter int MCB_C_W  = PKG_C_W,
  parameter int MCB_D_W  = 32,
  parameter int MCB_BE_W = MCB_D_W / 8,
  parameter int MEM_A_W  = 10,
  parameter int RD_LAT   = 3,
  parameter int WDAT_LAT = 2,
  parameter int INIT_CYC = 8
) (
  input  logic                csi_clockreset_clk,
  input  logic                csi_clockreset_reset,
  input  logic                mcb_bb,
  input  logic                mcb_wr_n,
  input  logic [1:0]          mcb_bl,
  input  logic [MCB_B_W-1:0]  mcb_ba,
  input  logic [MCB_R_W-1:0]  mcb_ra,
  input  logic [MCB_C_W-1:0]  mcb_ca,
  output logic                mcb_busy,
  output logic                mcb_i_ready,
  output logic                mcb_wdat_req,
  input  logic [MCB_D_W-1:0]  mcb_wdat,
  input  logic [MCB_BE_W-1:0] mcb_wbe,
  output logic                mcb_rdat_vld,
  output logic [MCB_D_W-1:0]  mcb_rdat,
  output logic                cmd_err
);

  localparam int INIT_W = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;

  state_e              state;
  logic [INIT_W-1:0]   init_cnt;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [MCB_B_W-1:0]  ba_q;
  logic [MCB_R_W-1:0]  ra_q;
  logic [MCB_C_W-1:0]  col_q;
  logic [MEM_A_W-1:0]  cur_addr;
  logic                accept;
  logic                wr_push;
  logic                rd_issue;
  logic                beat_last;

  logic [MEM_A_W-1:0]  wa_p [WDAT_LAT];
  logic [WDAT_LAT-1:0] wvld_p;
  logic [WDAT_LAT-1:0] wlast_p;
  logic [RD_LAT-1:0]   rvld_p;
  logic [RD_LAT-1:0]   rlast_p;
  logic [MCB_D_W-1:0]  ram_q;
  logic                wr_done;
  logic                rd_done;

  assign accept    = (state == ST_IDLE) && mcb_bb && (mcb_bl != BL_ILLEGAL);
  assign wr_push   = (state == ST_WR);
  assign rd_issue  = (state == ST_RD);
  assign beat_last = (beat_cnt == '0);
  assign cur_addr  = MEM_A_W'(mem_addr(ba_q, ra_q, col_q));
  assign wr_done   = wvld_p[WDAT_LAT-1] & wlast_p[WDAT_LAT-1];
  assign rd_done   = rvld_p[RD_LAT-1] & rlast_p[RD_LAT-1];

  assign mcb_busy     = (state != ST_IDLE) | mcb_bb;
  assign mcb_rdat_vld = rvld_p[RD_LAT-1];

  always_ff @(posedge csi_clockreset_clk or posedge csi_clockreset_reset) begin
    if (csi_clockreset_reset) begin
      state        <= ST_INIT;
      init_cnt     <= '0;
      beat_cnt     <= '0;
      mcb_i_ready  <= 1'b0;
      mcb_wdat_req <= 1'b0;
      cmd_err      <= 1'b0;
    end else begin
      if (mcb_bb && ((state != ST_IDLE) || (mcb_bl == BL_ILLEGAL) || (mcb_ca[1:0] != 2'b00)))
        cmd_err <= 1'b1;
      unique case (state)
        ST_INIT: begin
          if (init_cnt == INIT_W'(INIT_CYC - 1)) begin
            state       <= ST_IDLE;
            mcb_i_ready <= 1'b1;
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (accept) begin
            beat_cnt     <= beat_count(mcb_bl) - 1'b1;
            state        <= mcb_wr_n ? ST_RD : ST_WR;
            mcb_wdat_req <= ~mcb_wr_n;
          end
        end
        ST_WR: begin
          if (beat_last) begin
            state        <= ST_WR_DRAIN;
            mcb_wdat_req <= 1'b0;
          end else begin
            beat_cnt <= beat_cnt - 1'b1;
          end
        end
        ST_WR_DRAIN: if (wr_done) state <= ST_IDLE;
        ST_RD: begin
          if (beat_last) state <= ST_RD_DRAIN;
          else           beat_cnt <= beat_cnt - 1'b1;
        end
        ST_RD_DRAIN: if (rd_done) state <= ST_IDLE;
        default: state <= ST_INIT;
      endcase
    end
  end

  // Command capture; column advances once per issued beat and wraps in-row.
  always_ff @(posedge csi_clockreset_clk) begin
    if (accept) begin
      ba_q  <= mcb_ba;
      ra_q  <= mcb_ra;
      col_q <= mcb_ca;
    end else if (wr_push || rd_issue) begin
      col_q <= col_q + 1'b1;
    end
  end

  // Stage p0..: write beat address waits WDAT_LAT cycles for its data.
  always_ff @(posedge csi_clockreset_clk) begin
    wa_p[0] <= cur_addr;
    for (int k = 1; k < WDAT_LAT; k++) wa_p[k] <= wa_p[k-1];
  end

  always_ff @(posedge csi_clockreset_clk or posedge csi_clockreset_reset) begin
    if (csi_clockreset_reset) begin
      wvld_p  <= '0;
      wlast_p <= '0;
      rvld_p  <= '0;
      rlast_p <= '0;
    end else begin
      wvld_p[0]  <= wr_push;
      wlast_p[0] <= wr_push & beat_last;
      rvld_p[0]  <= rd_issue;
      rlast_p[0] <= rd_issue & beat_last;
      for (int k = 1; k < WDAT_LAT; k++) begin
        wvld_p[k]  <= wvld_p[k-1];
        wlast_p[k] <= wlast_p[k-1];
      end
      for (int k = 1; k < RD_LAT; k++) begin
        rvld_p[k]  <= rvld_p[k-1];
        rlast_p[k] <= rlast_p[k-1];
      end
    end
  end

  mcb_resp_ram #(
    .A_W  (MEM_A_W),
    .D_W  (MCB_D_W),
    .BE_W (MCB_BE_W)
  ) u_ram (
    .clk   (csi_clockreset_clk),
    .rst   (csi_clockreset_reset),
    .we    (wvld_p[WDAT_LAT-1]),
    .waddr (wa_p[WDAT_LAT-1]),
    .wdata (mcb_wdat),
    .wbe   (mcb_wbe),
    .re    (rd_issue),
    .raddr (cur_addr),
    .rdata (ram_q)
  );

  // Stage p1..: remaining read latency; each stage loads only with a valid
  // beat so the output holds its last value between bursts.
  generate
    if (RD_LAT == 1) begin : g_rd_direct
      assign mcb_rdat = ram_q;
    end else begin : g_rd_pipe
      logic [MCB_D_W-1:0] rd_p [1:RD_LAT-1];
      always_ff @(posedge csi_clockreset_clk or posedge csi_clockreset_reset) begin
        if (csi_clockreset_reset) begin
          for (int k = 1; k < RD_LAT; k++) rd_p[k] <= '0;
        end else begin
          if (rvld_p[0]) rd_p[1] <= ram_q;
          for (int k = 2; k < RD_LAT; k++) begin
            if (rvld_p[k-1]) rd_p[k] <= rd_p[k-1];
          end
        end
      end
      assign mcb_rdat = rd_p[RD_LAT-1];
    end
  endgenerate

endmodule
